fmap_stream_reader: RTL and testbench
=====================================

# fmap_stream_reader

Read-side initiator for the single-port feature-map memory. On `start` it issues a burst of sequential reads (`base_addr` … `base_addr+length-1`, wrapping at `MEM_SIZE`) and absorbs the memory's 1-cycle registered read latency. It returns the words as a valid/ready stream with full backpressure support, feeding the convolution/pooling datapath of the LeNet-5 pipeline.

## Interface
- `DATA_WIDTH`, 32, word width; matches the memory.
- `MEM_SIZE`, 28*28, memory depth in words.
- `ADDR_WIDTH`, $clog2(MEM_SIZE), address width (derived).
- `LEN_WIDTH`, $clog2(MEM_SIZE+1), width of `length` (derived).

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: burst request; sampled only in IDLE.
- `base_addr` in ADDR_WIDTH: first word address; captured with `start`.
- `length` in LEN_WIDTH: word count; 0..MEM_SIZE; captured with `start`.
- `busy` out 1: high from the cycle after `start` acceptance until `done`.
- `done` out 1: one-cycle pulse at burst completion.
- `mem_rd_en` out 1: to memory `Enable_Read`.
- `mem_addr` out ADDR_WIDTH: to memory `Address`.
- `mem_rd_data` in DATA_WIDTH: from memory `Data_Output`; valid the cycle after `mem_rd_en`.
- `out_valid` out 1: stream word available.
- `out_ready` in 1: consumer accepts.
- `out_data` out DATA_WIDTH: stream word.
- `out_last` out 1: qualifies the final word of the burst.

## Operation
- States:
  - IDLE: `start`=1 → READ. If `length`==0, go to DONE directly.
  - READ: issue reads; after the last read is issued → DRAIN.
  - DRAIN: wait for the FIFO to empty and no read in flight → DONE.
  - DONE: assert `done` for one cycle → IDLE.
- Reset values: state IDLE; `busy`, `done`, `mem_rd_en`, `out_valid`, `out_last` all 0; `mem_addr` 0; `out_data` 0; counters and FIFO cleared.
- Output buffering:
  - 2-entry FIFO. `inflight` is 1 in the cycle after a read is issued.
  - Read issued in a cycle iff in READ, reads remain, and `count + inflight - pop ≤ 1`, where `pop = out_valid & out_ready`. This guarantees no overflow.
  - `mem_rd_data` is pushed when `inflight`=1.
- Address: starts at `base_addr`, increments per issued read. Value MEM_SIZE-1 wraps to 0.
- `mem_addr` is held when `mem_rd_en`=0. No writes are ever issued; the memory's `Enable_Write` is owned elsewhere.
- `out_last` is high with the word whose index equals `length-1`.
- `start` while `busy` is ignored. `base_addr`/`length` changes after capture have no effect.
- `rst` mid-burst: immediate return to IDLE. In-flight data is discarded. `done` is not pulsed.
- `out_valid`/`out_data` are stable while `out_ready`=0. The stream never retracts a valid word.

## Timing
- E0 = edge sampling `start`.
- `mem_rd_en` first high in the cycle after E0.
- `out_valid` first high 2 cycles after the first `mem_rd_en` cycle.
- Throughput: 1 word/cycle with `out_ready` held high.
- Backpressure: at most 2 buffered words plus 0 in flight. `mem_rd_en` stays low while stalled.
- `done` asserts the cycle after the `out_last` handshake; `busy` falls in the same cycle.
- `length`=0: `done` 2 cycles after E0. No `mem_rd_en`, no `out_valid`.

## Structure
- Package `fmap_pkg`:
  - state enum (IDLE, READ, DRAIN, DONE)
  - default `DATA_WIDTH`/`MEM_SIZE` constants
  - address-wrap helper function
- Sub-module `fmap_skid_fifo`:
  - 2-entry synchronous FIFO with push/pop/count, parameterised by `DATA_WIDTH`
  - reset asynchronous active-high
- Top holds the FSM, address/issue/return counters and the `inflight` flag.
- Bench instantiates the single-port memory, preloaded with `Memory[i] = 3*i`.

## Test plan
- base 0, length 4, `out_ready`=1:
  - stream 0,3,6,9
  - `out_last` on 9
  - `done` one cycle after
  - exactly 4 `mem_rd_en` cycles
- base 782, length 4: addresses 782,783,0,1 → data 2346,2349,0,3.
- base 10, length 6, `out_ready` toggling 1,0,0,1 repeating:
  - data 30..45 in order, no loss or duplication
  - `out_data` stable while stalled
  - FIFO never exceeds 2
- length 0:
  - `done` pulse 2 cycles after `start`
  - no `mem_rd_en`, no `out_valid`
- `start` re-pulsed mid-burst (base 100, length 3): ignored; output stays 300,303,306.
- `rst` asserted after 2 words of a length-8 burst (base 0):
  - all outputs 0 immediately, no `done`
  - a new burst (base 5, length 2) yields 15,18

Source files
------------

// File: rtl/fmap_pkg.sv
// Shared types, default sizes and the address-wrap helper for the
// feature-map stream reader.
package fmap_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_MEM_SIZE   = 28 * 28;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } fmap_state_e;

    function automatic int unsigned fmap_wrap_inc(input int unsigned addr,
                                                  input int unsigned mem_size);
        return (addr >= mem_size - 32'd1) ? 32'd0 : addr + 32'd1;
    endfunction

endpackage

// File: rtl/fmap_stream_reader_if.sv
// Command, memory-port and output-stream signals of the feature-map reader;
// master is the reader, slave is whatever sits around it.
interface fmap_stream_reader_if
    import fmap_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MEM_SIZE   = DEFAULT_MEM_SIZE
);
    localparam int ADDR_WIDTH = $clog2(MEM_SIZE);
    localparam int LEN_WIDTH  = $clog2(MEM_SIZE + 1);

    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [LEN_WIDTH-1:0]  length;
    logic                  busy;
    logic                  done;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        input  start, base_addr, length, mem_rd_data, out_ready,
        output busy, done, mem_rd_en, mem_addr, out_valid, out_data, out_last
    );

    modport slave (
        output start, base_addr, length, mem_rd_data, out_ready,
        input  busy, done, mem_rd_en, mem_addr, out_valid, out_data, out_last
    );

endinterface

// File: rtl/fmap_skid_fifo.sv
// Two-entry FIFO that catches returning read words; head is visible
// combinationally so the stream word is stable until popped.
module fmap_skid_fifo
    import fmap_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [1:0]            count_o
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic                  do_push;
    logic                  do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fmap_stream_reader.sv
// Burst read initiator for the feature-map memory: issues sequential reads,
// soaks up the 1-cycle read latency and presents a valid/ready stream.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for start; captures base_addr/length
//   ST_READ  | issuing reads while buffer + in-flight leaves room
//   ST_DRAIN | all reads issued; waiting for the last word to be taken
//   ST_DONE  | pulses done, then back to idle
module fmap_stream_reader
    import fmap_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MEM_SIZE   = DEFAULT_MEM_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    fmap_stream_reader_if.master bus
);

    localparam int ADDR_WIDTH = $clog2(MEM_SIZE);
    localparam int LEN_WIDTH  = $clog2(MEM_SIZE + 1);

    fmap_state_e           state_q;
    logic                  busy_q;
    logic                  done_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  rd_left_q;
    logic [LEN_WIDTH-1:0]  ret_left_q;
    logic                  inflight_q;

    logic [DATA_WIDTH:0]   fifo_head;
    logic [1:0]            fifo_count;
    logic                  fifo_valid;
    logic                  pop;
    logic [2:0]            occ;
    logic                  rd_issue;
    logic                  push_last;

    assign fifo_valid = (fifo_count != 2'd0);
    assign pop        = fifo_valid && bus.out_ready;
    assign occ        = {1'b0, fifo_count} + {2'b0, inflight_q};
    // A slot freed by this cycle's pop can be reused by this cycle's read.
    assign rd_issue   = (state_q == ST_READ) &&
                        ((occ <= 3'd1) || ((occ == 3'd2) && pop));
    assign push_last  = (ret_left_q == LEN_WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            rd_left_q  <= '0;
            ret_left_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rd_issue;
            if (inflight_q) begin
                ret_left_q <= ret_left_q - LEN_WIDTH'(1);
            end
            if (rd_issue) begin
                addr_q    <= ADDR_WIDTH'(fmap_wrap_inc(32'(addr_q), MEM_SIZE));
                rd_left_q <= rd_left_q - LEN_WIDTH'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        addr_q     <= bus.base_addr;
                        rd_left_q  <= bus.length;
                        ret_left_q <= bus.length;
                        busy_q     <= 1'b1;
                        state_q    <= (bus.length == '0) ? ST_DONE : ST_READ;
                    end
                end
                ST_READ: begin
                    if (rd_issue && (rd_left_q == LEN_WIDTH'(1))) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && fifo_head[DATA_WIDTH]) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Zero-length bursts arrive with done still low and spend
                    // one extra cycle here before pulsing.
                    if (!done_q) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        done_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    fmap_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i ({push_last, bus.mem_rd_data}),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mem_rd_en = rd_issue;
    assign bus.mem_addr  = addr_q;
    assign bus.out_valid = fifo_valid;
    assign bus.out_data  = fifo_head[DATA_WIDTH-1:0];
    assign bus.out_last  = fifo_valid && fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_fmap_stream_reader.sv
// Bench for fmap_stream_reader: a registered-read memory holding 3*i and a
// reference model of the expected word sequence for each burst.
module tb_fmap_stream_reader;
    import fmap_pkg::*;

    localparam int DW = 32;
    localparam int MS = 28 * 28;
    localparam int AW = $clog2(MS);
    localparam int LW = $clog2(MS + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fmap_stream_reader_if #(.DATA_WIDTH(DW), .MEM_SIZE(MS)) bus ();

    fmap_stream_reader #(.DATA_WIDTH(DW), .MEM_SIZE(MS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    logic [DW-1:0] mem [MS];
    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int       ready_mode = 0;
    logic [3:0] ready_pat = 4'b1001;
    int       phase = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ready_pat[phase];
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
        phase = (phase + 1) % 4;
    end

    int rd_en_cnt, valid_cnt, first_rd, first_vld, stall_bad;
    int issued, accepted, max_out, done_cnt, done_cyc, last_hs_cyc, busy_at_done;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] got_data [$];
    bit            got_last [$];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_rd_en) begin
                rd_en_cnt++;
                issued++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (bus.out_valid) begin
                valid_cnt++;
                if (first_vld < 0) first_vld = cyc;
            end
            if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) stall_bad++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                got_data.push_back(bus.out_data);
                got_last.push_back(bus.out_last);
                last_hs_cyc = cyc;
                accepted++;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                if (bus.busy) busy_at_done++;
            end
            if (issued - accepted > max_out) max_out = issued - accepted;
        end
    end

    function automatic logic [DW-1:0] exp_word(input int b, input int k);
        return DW'(3 * ((b + k) % MS));
    endfunction

    task automatic clear_mon();
        rd_en_cnt = 0; valid_cnt = 0; first_rd = -1; first_vld = -1; stall_bad = 0;
        issued = 0; accepted = 0; max_out = 0; done_cnt = 0; done_cyc = -1;
        last_hs_cyc = -100; busy_at_done = 0; prev_stall = 1'b0;
        got_data.delete();
        got_last.delete();
    endtask

    task automatic launch(input int b, input int l, output int e0);
        @(posedge clk); #1;
        clear_mon();
        bus.start     = 1'b1;
        bus.base_addr = AW'(b);
        bus.length    = LW'(l);
        e0 = cyc + 1;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.base_addr = AW'($urandom_range(0, MS - 1));
        bus.length    = LW'($urandom_range(0, MS));
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        timed_out = (done_cnt == 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.busy, bus.done, bus.mem_rd_en, bus.out_valid, bus.out_last} !== 5'b0 ||
            bus.mem_addr !== '0 || bus.out_data !== '0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b done=%b rd_en=%b valid=%b last=%b addr=%0d data=%0d, expected all 0",
                     bus.busy, bus.done, bus.mem_rd_en, bus.out_valid, bus.out_last, bus.mem_addr, bus.out_data);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({bus.busy, bus.done, bus.mem_rd_en, bus.out_valid} !== 4'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b done=%b rd_en=%b valid=%b, expected 0",
                     bus.busy, bus.done, bus.mem_rd_en, bus.out_valid);
        end
    endtask

    task automatic test_basic();
        int e0; bit to;
        ready_mode = 0;
        launch(0, 4, e0);
        wait_done(100, to);
        tests++; if (to) begin fails++; $display("FAIL basic_timeout: no done within 100 cycles"); end
        tests++;
        if (got_data.size() != 4) begin
            fails++; $display("FAIL basic_count: got %0d words, expected 4", got_data.size());
        end
        for (int k = 0; k < 4 && k < got_data.size(); k++) begin
            tests++;
            if (got_data[k] !== exp_word(0, k) || got_last[k] !== (k == 3)) begin
                fails++;
                $display("FAIL basic_word[%0d]: got %0d last %0b, expected %0d last %0b",
                         k, got_data[k], got_last[k], exp_word(0, k), (k == 3));
            end
        end
        tests++; if (rd_en_cnt != 4) begin fails++; $display("FAIL basic_rd_en: %0d cycles, expected 4", rd_en_cnt); end
        tests++; if (first_rd != e0) begin fails++; $display("FAIL basic_rd_latency: cycle %0d, expected %0d", first_rd, e0); end
        tests++; if (first_vld != e0 + 2) begin fails++; $display("FAIL basic_valid_latency: cycle %0d, expected %0d", first_vld, e0 + 2); end
        tests++; if (done_cyc != last_hs_cyc + 1) begin fails++; $display("FAIL basic_done_time: cycle %0d, expected %0d", done_cyc, last_hs_cyc + 1); end
        tests++;
        if (done_cnt != 1 || busy_at_done != 0) begin
            fails++; $display("FAIL basic_done_pulse: pulses %0d busy_at_done %0d, expected 1 and 0", done_cnt, busy_at_done);
        end
    endtask

    task automatic test_wrap();
        int e0; bit to;
        ready_mode = 0;
        launch(782, 4, e0);
        wait_done(100, to);
        tests++;
        if (to || got_data.size() != 4) begin
            fails++; $display("FAIL wrap_count: got %0d words timeout %0b, expected 4 words", got_data.size(), to);
        end
        for (int k = 0; k < 4 && k < got_data.size(); k++) begin
            tests++;
            if (got_data[k] !== exp_word(782, k)) begin
                fails++; $display("FAIL wrap_word[%0d]: got %0d, expected %0d", k, got_data[k], exp_word(782, k));
            end
        end
    endtask

    task automatic test_backpressure();
        int e0; bit to;
        ready_mode = 1;
        launch(10, 6, e0);
        wait_done(200, to);
        tests++;
        if (to || got_data.size() != 6) begin
            fails++; $display("FAIL bp_count: got %0d words timeout %0b, expected 6 words", got_data.size(), to);
        end
        for (int k = 0; k < 6 && k < got_data.size(); k++) begin
            tests++;
            if (got_data[k] !== exp_word(10, k) || got_last[k] !== (k == 5)) begin
                fails++;
                $display("FAIL bp_word[%0d]: got %0d last %0b, expected %0d last %0b",
                         k, got_data[k], got_last[k], exp_word(10, k), (k == 5));
            end
        end
        tests++; if (stall_bad != 0) begin fails++; $display("FAIL bp_stable: %0d unstable stall cycles, expected 0", stall_bad); end
        tests++; if (max_out > 2) begin fails++; $display("FAIL bp_occupancy: peak %0d, expected at most 2", max_out); end
        tests++; if (rd_en_cnt != 6) begin fails++; $display("FAIL bp_rd_en: %0d cycles, expected 6", rd_en_cnt); end
        tests++; if (done_cyc != last_hs_cyc + 1) begin fails++; $display("FAIL bp_done_time: cycle %0d, expected %0d", done_cyc, last_hs_cyc + 1); end
    endtask

    task automatic test_zero_len();
        int e0; bit to;
        ready_mode = 0;
        launch(77, 0, e0);
        wait_done(20, to);
        tests++; if (done_cyc != e0 + 1) begin fails++; $display("FAIL zero_done_time: cycle %0d, expected %0d", done_cyc, e0 + 1); end
        tests++;
        if (rd_en_cnt != 0 || valid_cnt != 0) begin
            fails++; $display("FAIL zero_activity: rd_en %0d valid %0d, expected 0 and 0", rd_en_cnt, valid_cnt);
        end
        tests++;
        if (done_cnt != 1 || busy_at_done != 0) begin
            fails++; $display("FAIL zero_done_pulse: pulses %0d busy_at_done %0d, expected 1 and 0", done_cnt, busy_at_done);
        end
    endtask

    task automatic test_restart_ignored();
        int e0; bit to;
        ready_mode = 0;
        launch(100, 3, e0);
        bus.start = 1'b1; bus.base_addr = AW'(0); bus.length = LW'(5);
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(100, to);
        tests++;
        if (to || got_data.size() != 3 || rd_en_cnt != 3 || done_cnt != 1) begin
            fails++;
            $display("FAIL restart_count: words %0d rd_en %0d done %0d, expected 3 3 1",
                     got_data.size(), rd_en_cnt, done_cnt);
        end
        for (int k = 0; k < 3 && k < got_data.size(); k++) begin
            tests++;
            if (got_data[k] !== exp_word(100, k)) begin
                fails++; $display("FAIL restart_word[%0d]: got %0d, expected %0d", k, got_data[k], exp_word(100, k));
            end
        end
    endtask

    task automatic test_reset_mid();
        int e0; int n; bit to;
        ready_mode = 0;
        launch(0, 8, e0);
        n = 0;
        while (got_data.size() < 2 && n < 50) begin @(negedge clk); n++; end
        tests++; if (got_data.size() < 2) begin fails++; $display("FAIL rstmid_progress: %0d words, expected 2", got_data.size()); end
        rst = 1'b1;
        #1;
        tests++;
        if ({bus.busy, bus.done, bus.mem_rd_en, bus.out_valid, bus.out_last} !== 5'b0 ||
            bus.mem_addr !== '0 || bus.out_data !== '0) begin
            fails++;
            $display("FAIL rstmid_outputs: busy=%b done=%b rd_en=%b valid=%b last=%b addr=%0d data=%0d, expected all 0",
                     bus.busy, bus.done, bus.mem_rd_en, bus.out_valid, bus.out_last, bus.mem_addr, bus.out_data);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (done_cnt != 0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL rstmid_no_done: done pulses %0d busy %b, expected 0 and 0", done_cnt, bus.busy);
        end
        launch(5, 2, e0);
        wait_done(100, to);
        tests++;
        if (to || got_data.size() != 2) begin
            fails++; $display("FAIL rstmid_new_count: got %0d words timeout %0b, expected 2", got_data.size(), to);
        end
        for (int k = 0; k < 2 && k < got_data.size(); k++) begin
            tests++;
            if (got_data[k] !== exp_word(5, k) || got_last[k] !== (k == 1)) begin
                fails++;
                $display("FAIL rstmid_new_word[%0d]: got %0d last %0b, expected %0d last %0b",
                         k, got_data[k], got_last[k], exp_word(5, k), (k == 1));
            end
        end
    endtask

    task automatic test_random();
        int e0; int b; int l; bit to;
        ready_mode = 2;
        for (int r = 0; r < 8; r++) begin
            b = $urandom_range(0, MS - 1);
            l = (r == 0) ? 1 : $urandom_range(1, 12);
            launch(b, l, e0);
            wait_done(400, to);
            tests++;
            if (to || got_data.size() != l || rd_en_cnt != l) begin
                fails++;
                $display("FAIL rand_count[%0d]: base %0d words %0d rd_en %0d timeout %0b, expected %0d",
                         r, b, got_data.size(), rd_en_cnt, to, l);
            end
            for (int k = 0; k < l && k < got_data.size(); k++) begin
                tests++;
                if (got_data[k] !== exp_word(b, k) || got_last[k] !== (k == l - 1)) begin
                    fails++;
                    $display("FAIL rand_word[%0d][%0d]: got %0d last %0b, expected %0d last %0b",
                             r, k, got_data[k], got_last[k], exp_word(b, k), (k == l - 1));
                end
            end
            tests++;
            if (stall_bad != 0 || max_out > 2 || done_cyc != last_hs_cyc + 1) begin
                fails++;
                $display("FAIL rand_flow[%0d]: unstable %0d peak %0d done %0d, expected 0, <=2, %0d",
                         r, stall_bad, max_out, done_cyc, last_hs_cyc + 1);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < MS; i++) mem[i] = DW'(3 * i);
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        clear_mon();
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_restart_ignored();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
